// File: rtl/lsu_mem_if.sv
// Load/store initiator for the data RAM port: big-endian lanes, fixed read latency, pipeline stall.
// Optional alignment fault detection is enabled by defining MISALIGN_CHECK_EN.
module lsu_mem_if #(
    parameter int RAM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic              mem_ce_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_sel_o,
    output logic [31:0]       mem_data_o,
    input  logic [31:0]       mem_data_i
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LBU = 3'b001;
    localparam logic [2:0] OP_LH  = 3'b010;
    localparam logic [2:0] OP_LHU = 3'b011;
    localparam logic [2:0] OP_LW  = 3'b100;
    localparam logic [2:0] OP_SB  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    localparam logic [3:0] LAT_M1 = 4'(RAM_LAT - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_misalign;

    logic              w_access;
    logic              w_done;
    logic              w_in_misalign;
    logic              w_is_store;
    logic [3:0]        w_sel;
    logic [31:0]       w_wdata_rep;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load_ext;

    assign w_access   = (r_state == S_ACCESS);
    assign w_done     = (r_state == S_DONE);
    assign w_is_store = (r_op == OP_SB) || (r_op == OP_SH) || (r_op == OP_SW);

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        w_in_misalign = 1'b0;
        case (op_i)
            OP_LH, OP_LHU, OP_SH: w_in_misalign = addr_i[0];
            OP_LW, OP_SW:         w_in_misalign = |addr_i[1:0];
            default:              w_in_misalign = 1'b0;
        endcase
    end
`else
    assign w_in_misalign = 1'b0;
`endif

    // Half accesses key off addr[1] and words ignore addr[1:0], so a forced
    // alignment falls out naturally when the fault check is compiled out.
    always_comb begin
        w_sel       = 4'b0000;
        w_wdata_rep = 32'h0;
        case (r_op)
            OP_LB, OP_LBU, OP_SB: begin
                w_sel       = 4'b1000 >> r_addr[1:0];
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                w_sel       = r_addr[1] ? 4'b0011 : 4'b1100;
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_sel       = 4'b1111;
                w_wdata_rep = r_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = 8'h0;
        case (r_addr[1:0])
            2'b00:   w_byte = mem_data_i[31:24];
            2'b01:   w_byte = mem_data_i[23:16];
            2'b10:   w_byte = mem_data_i[15:8];
            default: w_byte = mem_data_i[7:0];
        endcase
    end

    assign w_half = r_addr[1] ? mem_data_i[15:0] : mem_data_i[31:16];

    always_comb begin
        w_load_ext = 32'h0;
        case (r_op)
            OP_LB:   w_load_ext = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_ext = {24'h0, w_byte};
            OP_LH:   w_load_ext = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_ext = {16'h0, w_half};
            OP_LW:   w_load_ext = mem_data_i;
            default: w_load_ext = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_op       <= 3'd0;
            r_addr     <= '0;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        r_op    <= op_i;
                        r_addr  <= addr_i;
                        r_wdata <= wdata_i;
                        r_rdata <= 32'h0;
                        if (w_in_misalign) begin
                            r_state    <= S_DONE;
                            r_misalign <= 1'b1;
                        end else begin
                            r_state    <= S_ACCESS;
                            r_cnt      <= LAT_M1;
                            r_misalign <= 1'b0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_rdata <= w_load_ext;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_misalign <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Every RAM-side output is qualified by ACCESS so nothing leaks out of IDLE/DONE.
    assign mem_ce_o   = w_access;
    assign mem_we_o   = w_access & w_is_store;
    assign mem_addr_o = w_access ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
    assign mem_sel_o  = w_access ? w_sel : 4'b0000;
    assign mem_data_o = (w_access & w_is_store) ? w_wdata_rep : 32'h0;

    assign done_o     = w_done;
    assign rdata_o    = w_done ? r_rdata : 32'h0;
    assign misalign_o = w_done & r_misalign;
    assign stall_o    = ((r_state == S_IDLE) & req_i) | w_access;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: one instance with RAM_LAT=1, one with RAM_LAT=3.
// Expectations for misaligned accesses follow whether MISALIGN_CHECK_EN is defined.
module tb_lsu_mem_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_init;
    logic        req1, req3;
    logic [2:0]  op;
    logic [31:0] addr, wdata;

    logic [31:0] rdata1, rdata3, maddr1, maddr3, mdo1, mdo3, mrd1, mrd3;
    logic        done1, done3, stall1, stall3, mis1, mis3, ce1, ce3, we1, we3;
    logic [3:0]  sel1, sel3;

    logic [31:0] ram1 [0:255];
    logic [31:0] ram3 [0:255];

    int n_cmp = 0;
    int n_err = 0;

    logic        use3 = 1'b0;
    logic        s_ce, s_we, s_done, s_stall, s_mis;
    logic [3:0]  s_sel;
    logic [31:0] s_rdata, s_maddr, s_dout;

    int          obs_ce, obs_we, obs_stall, obs_wait;
    logic        obs_mis, done_seen;
    logic [3:0]  obs_sel;
    logic [31:0] obs_rdata, obs_maddr, obs_dout;

    always #5 clk = ~clk;

    lsu_mem_if #(.RAM_LAT(1), .ADDR_W(32)) dut1 (
        .clk(clk), .rst(rst), .req_i(req1), .op_i(op), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata1), .done_o(done1), .stall_o(stall1), .misalign_o(mis1),
        .mem_ce_o(ce1), .mem_we_o(we1), .mem_addr_o(maddr1), .mem_sel_o(sel1),
        .mem_data_o(mdo1), .mem_data_i(mrd1)
    );

    lsu_mem_if #(.RAM_LAT(3), .ADDR_W(32)) dut3 (
        .clk(clk), .rst(rst), .req_i(req3), .op_i(op), .addr_i(addr), .wdata_i(wdata),
        .rdata_o(rdata3), .done_o(done3), .stall_o(stall3), .misalign_o(mis3),
        .mem_ce_o(ce3), .mem_we_o(we3), .mem_addr_o(maddr3), .mem_sel_o(sel3),
        .mem_data_o(mdo3), .mem_data_i(mrd3)
    );

    assign mrd1 = ram1[maddr1[9:2]];
    assign mrd3 = ram3[maddr3[9:2]];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 256; k++) begin
                ram1[k] <= 32'h0;
                ram3[k] <= 32'h0;
            end
            ram1[8'h40] <= 32'h8899AABB;
            ram1[8'h80] <= 32'hCAFE0000;
            ram3[8'h40] <= 32'h8899AABB;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (ce1 && we1 && sel1[k]) ram1[maddr1[9:2]][8*k +: 8] <= mdo1[8*k +: 8];
                if (ce3 && we3 && sel3[k]) ram3[maddr3[9:2]][8*k +: 8] <= mdo3[8*k +: 8];
            end
        end
    end

    assign s_ce    = use3 ? ce3    : ce1;
    assign s_we    = use3 ? we3    : we1;
    assign s_done  = use3 ? done3  : done1;
    assign s_stall = use3 ? stall3 : stall1;
    assign s_mis   = use3 ? mis3   : mis1;
    assign s_sel   = use3 ? sel3   : sel1;
    assign s_rdata = use3 ? rdata3 : rdata1;
    assign s_maddr = use3 ? maddr3 : maddr1;
    assign s_dout  = use3 ? mdo3   : mdo1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    // Issues one request, holds it until done_o, and records what the RAM port did.
    task automatic access(input logic u3, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] wd);
        @(negedge clk);
        use3 = u3; op = o; addr = a; wdata = wd;
        if (u3) req3 = 1'b1; else req1 = 1'b1;
        #1;
        obs_stall = int'(s_stall);
        obs_ce = 0; obs_we = 0; obs_wait = 0; done_seen = 1'b0;
        obs_sel = 4'h0; obs_maddr = 32'h0; obs_dout = 32'h0; obs_rdata = 32'h0; obs_mis = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            obs_wait++;
            obs_stall += int'(s_stall);
            if (s_ce) begin
                obs_ce++;
                obs_sel = s_sel; obs_maddr = s_maddr; obs_dout = s_dout;
            end
            if (s_we) obs_we++;
            if (s_done) begin
                obs_rdata = s_rdata; obs_mis = s_mis; done_seen = 1'b1;
                break;
            end
        end
        req1 = 1'b0; req3 = 1'b0;
        chk("done_timeout", done_seen, 1);
        @(negedge clk);
        chk("done_pulse", s_done, 0);
        chk("rdata_idle", s_rdata, 0);
        $display("access op=%0d addr=%h wd=%h: wait=%0d ce=%0d we=%0d stall=%0d sel=%b rdata=%h mis=%b",
                 o, a, wd, obs_wait, obs_ce, obs_we, obs_stall, obs_sel, obs_rdata, obs_mis);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        rst = 1'b1; ram_init = 1'b1; req1 = 1'b0; req3 = 1'b0;
        op = 3'd0; addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ce", ce1, 0);
        chk("rst_we", we1, 0);
        chk("rst_sel", sel1, 0);
        chk("rst_addr", maddr1, 0);
        chk("rst_data", mdo1, 0);
        chk("rst_done", done1, 0);
        chk("rst_stall", stall1, 0);
        chk("rst_rdata", rdata1, 0);
        chk("rst_mis", mis1, 0);
        rst = 1'b0; ram_init = 1'b0;

        access(1'b0, 3'b100, 32'h100, 32'h0);          // LW
        chk("lw_ce", obs_ce, 1);
        chk("lw_sel", obs_sel, 4'b1111);
        chk("lw_maddr", obs_maddr, 32'h100);
        chk("lw_wait", obs_wait, 2);
        chk("lw_stall", obs_stall, 2);
        chk("lw_rdata", obs_rdata, 32'h8899AABB);
        chk("lw_mis", obs_mis, 0);
        chk("lw_we", obs_we, 0);

        access(1'b0, 3'b000, 32'h103, 32'h0);          // LB
        chk("lb3_sel", obs_sel, 4'b0001);
        chk("lb3_rdata", obs_rdata, 32'hFFFFFFBB);
        access(1'b0, 3'b001, 32'h103, 32'h0);          // LBU
        chk("lbu3_rdata", obs_rdata, 32'h000000BB);
        access(1'b0, 3'b000, 32'h100, 32'h0);          // LB
        chk("lb0_sel", obs_sel, 4'b1000);
        chk("lb0_rdata", obs_rdata, 32'hFFFFFF88);
        access(1'b0, 3'b011, 32'h102, 32'h0);          // LHU
        chk("lhu2_sel", obs_sel, 4'b0011);
        chk("lhu2_rdata", obs_rdata, 32'h0000AABB);

        access(1'b0, 3'b110, 32'h202, 32'h00001234);   // SH
        chk("sh_we", obs_we, 1);
        chk("sh_sel", obs_sel, 4'b0011);
        chk("sh_dout", obs_dout, 32'h12341234);
        chk("sh_maddr", obs_maddr, 32'h200);
        chk("sh_ram", ram1[8'h80], 32'hCAFE1234);
        access(1'b0, 3'b100, 32'h200, 32'h0);          // LW
        chk("lw200_rdata", obs_rdata, 32'hCAFE1234);

        access(1'b0, 3'b101, 32'h301, 32'h0000005A);   // SB
        chk("sb_sel", obs_sel, 4'b0100);
        chk("sb_dout", obs_dout, 32'h5A5A5A5A);
        chk("sb_ram", ram1[8'hC0], 32'h005A0000);

        access(1'b0, 3'b010, 32'h101, 32'h0);          // LH, odd address
`ifdef MISALIGN_CHECK_EN
        chk("lh1_mis", obs_mis, 1);
        chk("lh1_ce", obs_ce, 0);
        chk("lh1_wait", obs_wait, 1);
        chk("lh1_rdata", obs_rdata, 0);
`else
        chk("lh1_mis", obs_mis, 0);
        chk("lh1_sel", obs_sel, 4'b1100);
        chk("lh1_rdata", obs_rdata, 32'hFFFF8899);
`endif

        access(1'b0, 3'b111, 32'h101, 32'h11223344);   // SW, misaligned
`ifdef MISALIGN_CHECK_EN
        chk("sw1_ce", obs_ce, 0);
        chk("sw1_we", obs_we, 0);
        chk("sw1_mis", obs_mis, 1);
        chk("sw1_wait", obs_wait, 1);
        chk("sw1_ram", ram1[8'h40], 32'h8899AABB);
`else
        chk("sw1_we", obs_we, 1);
        chk("sw1_maddr", obs_maddr, 32'h100);
        chk("sw1_sel", obs_sel, 4'b1111);
        chk("sw1_mis", obs_mis, 0);
        chk("sw1_ram", ram1[8'h40], 32'h11223344);
`endif

        access(1'b1, 3'b010, 32'h100, 32'h0);          // LH, RAM_LAT=3
        chk("lh3_ce", obs_ce, 3);
        chk("lh3_stall", obs_stall, 4);
        chk("lh3_wait", obs_wait, 4);
        chk("lh3_sel", obs_sel, 4'b1100);
        chk("lh3_rdata", obs_rdata, 32'hFFFF8899);

        // Reset during the second ACCESS cycle of a RAM_LAT=3 store.
        @(negedge clk);
        use3 = 1'b1; op = 3'b111; addr = 32'h140; wdata = 32'hDEADBEEF; req3 = 1'b1;
        @(negedge clk);
        chk("rsw_ce1", ce3, 1);
        @(negedge clk);
        chk("rsw_ce2", ce3, 1);
        rst = 1'b1; req3 = 1'b0;
        @(negedge clk);
        chk("rsw_ce", ce3, 0);
        chk("rsw_we", we3, 0);
        chk("rsw_sel", sel3, 0);
        chk("rsw_addr", maddr3, 0);
        chk("rsw_data", mdo3, 0);
        chk("rsw_done", done3, 0);
        chk("rsw_stall", stall3, 0);
        rst = 1'b0;
        dcnt = 0;
        repeat (5) begin
            @(negedge clk);
            dcnt += int'(done3);
        end
        chk("rsw_nodone", dcnt, 0);

        access(1'b1, 3'b100, 32'h100, 32'h0);          // LW after reset
        chk("post_wait", obs_wait, 4);
        chk("post_rdata", obs_rdata, 32'h8899AABB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
